// File: rtl/ast_pkt_demux_pkg.sv
// Shared types and default parameters for the Avalon-ST packet demultiplexer.
//   DEF_*            default widths/counts used by ast_pkt_demux parameters
//   demux_state_t    packet-routing FSM state encoding
//   dir_sel_width()  width of a direction index for a given direction count
package usr_types_and_params;

  localparam int DEF_DATA_WIDTH    = 64;
  localparam int DEF_CHANNEL_WIDTH = 10;
  localparam int DEF_TX_DIR        = 4;
  localparam int DEF_STAT_WIDTH    = 16;
  localparam int DEF_EMPTY_WIDTH   = $clog2(DEF_DATA_WIDTH / 8);
  localparam int DEF_DIR_SEL_WIDTH = (DEF_TX_DIR == 1) ? 1 : $clog2(DEF_TX_DIR);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUTE = 2'd1,
    ST_DROP  = 2'd2
  } demux_state_t;

  // A single direction still needs a 1-bit select so ports never go zero-width.
  function automatic int dir_sel_width(input int tx_dir);
    return (tx_dir == 1) ? 1 : $clog2(tx_dir);
  endfunction

endpackage

// File: rtl/ast_pkt_demux_out_reg.sv
// One output register stage of the packet demultiplexer (one per direction).
// Optional packet counter enabled by macro AST_PKT_DEMUX_STAT_EN.
//   clk, srst         clock, synchronous active-high reset
//   load              capture the input beat this cycle (caller checked free)
//   data..channel     input beat fields
//   ready             downstream backpressure for this direction
//   free              stage can take a beat this cycle (empty or draining)
//   valid_q..channel_q registered output beat
//   pkt_cnt           completed-packet count (saturating), 0 when disabled
module ast_pkt_demux_out_reg #(
  parameter int DATA_WIDTH    = 64,
  parameter int CHANNEL_WIDTH = 10,
  parameter int EMPTY_WIDTH   = 3,
  parameter int STAT_WIDTH    = 16
) (
  input  logic                     clk,
  input  logic                     srst,
  input  logic                     load,
  input  logic [DATA_WIDTH-1:0]    data,
  input  logic                     sop,
  input  logic                     eop,
  input  logic [EMPTY_WIDTH-1:0]   empty,
  input  logic [CHANNEL_WIDTH-1:0] channel,
  input  logic                     ready,
  output logic                     free,
  output logic                     valid_q,
  output logic [DATA_WIDTH-1:0]    data_q,
  output logic                     sop_q,
  output logic                     eop_q,
  output logic [EMPTY_WIDTH-1:0]   empty_q,
  output logic [CHANNEL_WIDTH-1:0] channel_q,
  output logic [STAT_WIDTH-1:0]    pkt_cnt
);

  // Draining and refilling in the same cycle keeps full throughput.
  assign free = !valid_q || ready;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (srst) begin
      valid_q <= 1'b0;
    end else if (load) begin
      valid_q <= 1'b1;
    end else if (ready) begin
      valid_q <= 1'b0;
    end
  end

  // NOTE: payload registers carry no reset; valid_q alone qualifies them,
  // which keeps the wide datapath free of reset fan-out.
  always_ff @(posedge clk) begin
    if (load) begin
      data_q    <= data;
      sop_q     <= sop;
      eop_q     <= eop;
      empty_q   <= eop ? empty : '0;
      channel_q <= channel;
    end
  end

`ifdef AST_PKT_DEMUX_STAT_EN
  always_ff @(posedge clk) begin
    if (srst) begin
      pkt_cnt <= '0;
    end else if (valid_q && ready && eop_q && !(&pkt_cnt)) begin
      pkt_cnt <= pkt_cnt + 1'b1;
    end
  end
`else
  assign pkt_cnt = '0;
`endif

endmodule

// File: rtl/ast_pkt_demux.sv
// Avalon-ST packet demultiplexer: routes each packet to the direction given
// by dir_i on its SOP beat; packets with an out-of-range direction and
// stray beats outside a packet are consumed and dropped.
// Optional per-direction packet counters: macro AST_PKT_DEMUX_STAT_EN.
//   clk_i, srst_i          clock, synchronous active-high reset
//   ast_*_i, dir_i         input stream and SOP-time destination
//   ast_ready_o            input backpressure
//   ast_*_o, ast_ready_i   TX_DIR output streams with own backpressure
//   pkt_cnt_o              completed packets per direction
module ast_pkt_demux
  import usr_types_and_params::*;
#(
  parameter  int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter  int CHANNEL_WIDTH = DEF_CHANNEL_WIDTH,
  parameter  int TX_DIR        = DEF_TX_DIR,
  parameter  int STAT_WIDTH    = DEF_STAT_WIDTH,
  localparam int EMPTY_WIDTH   = $clog2(DATA_WIDTH / 8),
  localparam int DIR_SEL_WIDTH = dir_sel_width(TX_DIR)
) (
  input  logic                                  clk_i,
  input  logic                                  srst_i,
  input  logic [DATA_WIDTH-1:0]                 ast_data_i,
  input  logic                                  ast_startofpacket_i,
  input  logic                                  ast_endofpacket_i,
  input  logic                                  ast_valid_i,
  input  logic [EMPTY_WIDTH-1:0]                ast_empty_i,
  input  logic [CHANNEL_WIDTH-1:0]              ast_channel_i,
  input  logic [DIR_SEL_WIDTH-1:0]              dir_i,
  output logic                                  ast_ready_o,
  output logic [TX_DIR-1:0][DATA_WIDTH-1:0]     ast_data_o,
  output logic [TX_DIR-1:0]                     ast_startofpacket_o,
  output logic [TX_DIR-1:0]                     ast_endofpacket_o,
  output logic [TX_DIR-1:0]                     ast_valid_o,
  output logic [TX_DIR-1:0][EMPTY_WIDTH-1:0]    ast_empty_o,
  output logic [TX_DIR-1:0][CHANNEL_WIDTH-1:0]  ast_channel_o,
  input  logic [TX_DIR-1:0]                     ast_ready_i,
  output logic [TX_DIR-1:0][STAT_WIDTH-1:0]     pkt_cnt_o
);

  demux_state_t             state, state_nxt;
  logic [DIR_SEL_WIDTH-1:0] sel;
  logic [DIR_SEL_WIDTH-1:0] tgt;
  logic                     dir_ok;
  logic                     fwd;
  logic                     accept;
  logic [TX_DIR-1:0]        free;
  logic [TX_DIR-1:0]        load;

  // One extra bit so TX_DIR itself is representable in the comparison.
  assign dir_ok = ({1'b0, dir_i} < (DIR_SEL_WIDTH + 1)'(TX_DIR));

  // State register; the destination is captured only on a routable SOP.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state <= ST_IDLE;
      sel   <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_IDLE && accept && ast_startofpacket_i && dir_ok) begin
        sel <= dir_i;
      end
    end
  end

  // Next state. A SOP+EOP beat is a whole packet, so IDLE is kept.
  always_comb begin
    // NOTE: default assignment first so no path leaves a variable unassigned
    // (which would infer a latch).
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (accept && ast_startofpacket_i && !ast_endofpacket_i) begin
          state_nxt = dir_ok ? ST_ROUTE : ST_DROP;
        end
      end
      ST_ROUTE, ST_DROP: begin
        if (accept && ast_endofpacket_i) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Outputs: ready follows the target stage; dropped beats never stall.
  always_comb begin
    tgt         = (state == ST_ROUTE) ? sel : dir_i;
    fwd         = 1'b0;
    ast_ready_o = 1'b0;
    case (state)
      ST_IDLE: begin
        fwd         = ast_startofpacket_i && dir_ok;
        ast_ready_o = dir_ok ? free[tgt] : 1'b1;
      end
      ST_ROUTE: begin
        fwd         = 1'b1;
        ast_ready_o = free[tgt];
      end
      ST_DROP: ast_ready_o = 1'b1;
      default: ;
    endcase
    if (srst_i) ast_ready_o = 1'b0;
    accept = ast_valid_i && ast_ready_o;
    for (int d = 0; d < TX_DIR; d++) begin
      load[d] = accept && fwd && (tgt == DIR_SEL_WIDTH'(d));
    end
  end

  for (genvar d = 0; d < TX_DIR; d++) begin : g_dir
    ast_pkt_demux_out_reg #(
      .DATA_WIDTH   (DATA_WIDTH),
      .CHANNEL_WIDTH(CHANNEL_WIDTH),
      .EMPTY_WIDTH  (EMPTY_WIDTH),
      .STAT_WIDTH   (STAT_WIDTH)
    ) u_out_reg (
      .clk      (clk_i),
      .srst     (srst_i),
      .load     (load[d]),
      .data     (ast_data_i),
      .sop      (ast_startofpacket_i),
      .eop      (ast_endofpacket_i),
      .empty    (ast_empty_i),
      .channel  (ast_channel_i),
      .ready    (ast_ready_i[d]),
      .free     (free[d]),
      .valid_q  (ast_valid_o[d]),
      .data_q   (ast_data_o[d]),
      .sop_q    (ast_startofpacket_o[d]),
      .eop_q    (ast_endofpacket_o[d]),
      .empty_q  (ast_empty_o[d]),
      .channel_q(ast_channel_o[d]),
      .pkt_cnt  (pkt_cnt_o[d])
    );
  end

endmodule

// File: tb/tb_ast_pkt_demux.sv
// Self-checking bench for ast_pkt_demux (TX_DIR=3, STAT_WIDTH=4).
// Table of per-cycle vectors plus directed backpressure, mid-packet reset
// and counter-saturation sequences. Counter expectations follow macro
// AST_PKT_DEMUX_STAT_EN.
module tb_ast_pkt_demux;

  localparam int DW  = 32;
  localparam int CW  = 8;
  localparam int TXD = 3;
  localparam int SW  = 4;
  localparam int EW  = 2;
  localparam int DSW = 2;
`ifdef AST_PKT_DEMUX_STAT_EN
  localparam bit STAT_EN = 1'b1;
`else
  localparam bit STAT_EN = 1'b0;
`endif

  logic                    clk = 1'b0;
  logic                    srst;
  logic [DW-1:0]           ast_data_i;
  logic                    ast_startofpacket_i;
  logic                    ast_endofpacket_i;
  logic                    ast_valid_i;
  logic [EW-1:0]           ast_empty_i;
  logic [CW-1:0]           ast_channel_i;
  logic [DSW-1:0]          dir_i;
  logic                    ast_ready_o;
  logic [TXD-1:0][DW-1:0]  ast_data_o;
  logic [TXD-1:0]          ast_startofpacket_o;
  logic [TXD-1:0]          ast_endofpacket_o;
  logic [TXD-1:0]          ast_valid_o;
  logic [TXD-1:0][EW-1:0]  ast_empty_o;
  logic [TXD-1:0][CW-1:0]  ast_channel_o;
  logic [TXD-1:0]          ast_ready_i;
  logic [TXD-1:0][SW-1:0]  pkt_cnt_o;

  always #5 clk = ~clk;

  ast_pkt_demux #(
    .DATA_WIDTH   (DW),
    .CHANNEL_WIDTH(CW),
    .TX_DIR       (TXD),
    .STAT_WIDTH   (SW)
  ) dut (
    .clk_i              (clk),
    .srst_i             (srst),
    .ast_data_i         (ast_data_i),
    .ast_startofpacket_i(ast_startofpacket_i),
    .ast_endofpacket_i  (ast_endofpacket_i),
    .ast_valid_i        (ast_valid_i),
    .ast_empty_i        (ast_empty_i),
    .ast_channel_i      (ast_channel_i),
    .dir_i              (dir_i),
    .ast_ready_o        (ast_ready_o),
    .ast_data_o         (ast_data_o),
    .ast_startofpacket_o(ast_startofpacket_o),
    .ast_endofpacket_o  (ast_endofpacket_o),
    .ast_valid_o        (ast_valid_o),
    .ast_empty_o        (ast_empty_o),
    .ast_channel_o      (ast_channel_o),
    .ast_ready_i        (ast_ready_i),
    .pkt_cnt_o          (pkt_cnt_o)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // One input beat and what must appear one cycle later (vdir >= TXD: nothing).
  typedef struct {
    logic          vld, sop, eop;
    logic [DSW-1:0] dir;
    logic [EW-1:0] emp;
    logic [DW-1:0] data;
    int            vdir;
    logic          rdy;
    logic          xsop, xeop;
    logic [EW-1:0] xemp;
  } vec_t;

  function automatic vec_t mk(input bit vld, sop, eop, input int dir, emp,
                              input logic [DW-1:0] data, input int vdir,
                              input bit rdy, xsop, xeop, input int xemp);
    vec_t v;
    v.vld = vld; v.sop = sop; v.eop = eop;
    v.dir = DSW'(dir); v.emp = EW'(emp); v.data = data;
    v.vdir = vdir; v.rdy = rdy; v.xsop = xsop; v.xeop = xeop; v.xemp = EW'(xemp);
    return v;
  endfunction

  vec_t          tbl[$];
  logic [SW-1:0] exp_cnt [TXD];
  logic [DW-1:0] mon0[$];

  // Records every completed handshake on direction 0.
  always @(posedge clk) begin
    if (!srst && ast_valid_o[0] && ast_ready_i[0]) mon0.push_back(ast_data_o[0]);
  end

  task automatic drive(input bit vld, sop, eop, input int dir, emp, input logic [DW-1:0] data);
    ast_valid_i         = vld;
    ast_startofpacket_i = sop;
    ast_endofpacket_i   = eop;
    dir_i               = DSW'(dir);
    ast_empty_i         = EW'(emp);
    ast_data_i          = data;
    ast_channel_i       = data[CW-1:0];
  endtask

  task automatic apply_vec(input vec_t v, input int i);
    logic [TXD-1:0] xv;
    drive(v.vld, v.sop, v.eop, int'(v.dir), int'(v.emp), v.data);
    @(negedge clk);
    check($sformatf("v%0d.ready", i), ast_ready_o, v.rdy);
    @(posedge clk);
    #1;
    xv = (v.vdir < TXD) ? (TXD'(1) << v.vdir) : '0;
    check($sformatf("v%0d.valid", i), ast_valid_o, xv);
    if (v.vdir < TXD) begin
      check($sformatf("v%0d.data", i), ast_data_o[v.vdir], v.data);
      check($sformatf("v%0d.sop_eop", i),
            {ast_startofpacket_o[v.vdir], ast_endofpacket_o[v.vdir]}, {v.xsop, v.xeop});
      check($sformatf("v%0d.empty", i), ast_empty_o[v.vdir], v.xemp);
      check($sformatf("v%0d.channel", i), ast_channel_o[v.vdir], v.data[CW-1:0]);
    end
    check($sformatf("v%0d.cnt", i), pkt_cnt_o, {exp_cnt[2], exp_cnt[1], exp_cnt[0]});
    // This beat handshakes on the next edge (all ready), so it counts from then.
    if (v.vdir < TXD && v.xeop && STAT_EN && exp_cnt[v.vdir] != '1)
      exp_cnt[v.vdir] = exp_cnt[v.vdir] + 1'b1;
  endtask

  task automatic step_check_ready(input string name, input bit exp_rdy);
    @(negedge clk);
    check(name, ast_ready_o, exp_rdy);
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int d = 0; d < TXD; d++) exp_cnt[d] = '0;
    srst        = 1'b1;
    ast_ready_i = '1;
    drive(0, 0, 0, 0, 0, '0);

    // 3-beat packet to dir 2, empty only on EOP
    tbl.push_back(mk(1,1,0, 2,0, 32'hA100_0001, 2, 1, 1,0,0));
    tbl.push_back(mk(1,0,0, 0,1, 32'hA200_0002, 2, 1, 0,0,0));
    tbl.push_back(mk(1,0,1, 0,2, 32'hA300_0003, 2, 1, 0,1,2));
    tbl.push_back(mk(0,0,0, 0,0, 32'h0,         3, 1, 0,0,0));
    // single-beat packet to dir 1, FSM stays IDLE
    tbl.push_back(mk(1,1,1, 1,3, 32'hB100_0011, 1, 1, 1,1,3));
    tbl.push_back(mk(0,0,0, 0,0, 32'h0,         3, 1, 0,0,0));
    tbl.push_back(mk(1,1,1, 0,0, 32'hC100_0021, 0, 1, 1,1,0));
    // empty forced to 0 on a non-EOP beat
    tbl.push_back(mk(1,1,0, 0,3, 32'hD100_0031, 0, 1, 1,0,0));
    tbl.push_back(mk(1,0,1, 0,1, 32'hD200_0032, 0, 1, 0,1,1));
    // out-of-range dir 3: whole packet dropped, SOP inside drop ignored
    tbl.push_back(mk(1,1,0, 3,0, 32'hE100_0041, 3, 1, 0,0,0));
    tbl.push_back(mk(1,0,0, 3,0, 32'hE200_0042, 3, 1, 0,0,0));
    tbl.push_back(mk(1,1,0, 1,0, 32'hE300_0043, 3, 1, 0,0,0));
    tbl.push_back(mk(1,0,1, 0,0, 32'hE400_0044, 3, 1, 0,0,0));
    tbl.push_back(mk(1,1,1, 0,2, 32'hF100_0051, 0, 1, 1,1,2));
    // stray beats in IDLE discarded
    tbl.push_back(mk(1,0,0, 1,0, 32'h6100_0061, 3, 1, 0,0,0));
    tbl.push_back(mk(1,0,1, 1,0, 32'h6200_0062, 3, 1, 0,0,0));
    // SOP inside ROUTE keeps the original direction, SOP passed through
    tbl.push_back(mk(1,1,0, 1,0, 32'h7100_0071, 1, 1, 1,0,0));
    tbl.push_back(mk(1,1,0, 2,0, 32'h7200_0072, 1, 1, 1,0,0));
    tbl.push_back(mk(1,0,1, 2,1, 32'h7300_0073, 1, 1, 0,1,1));
    tbl.push_back(mk(0,0,0, 0,0, 32'h0,         3, 1, 0,0,0));

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst.ready", ast_ready_o, 1'b0);
    check("rst.valid", ast_valid_o, '0);
    check("rst.cnt", pkt_cnt_o, '0);
    @(posedge clk);
    #1;
    srst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) apply_vec(tbl[i], i);

    // Backpressure on dir 0 for 5 cycles mid-packet
    mon0.delete();
    drive(1, 1, 0, 0, 0, 32'h5000_0001);
    step_check_ready("bp.p1.ready", 1'b1);
    ast_ready_i = 3'b110;
    drive(1, 0, 0, 0, 0, 32'h5000_0002);
    for (int c = 0; c < 5; c++) begin
      step_check_ready($sformatf("bp.hold%0d.ready", c), 1'b0);
      check($sformatf("bp.hold%0d.valid", c), ast_valid_o[0], 1'b1);
      check($sformatf("bp.hold%0d.data", c), ast_data_o[0], 32'h5000_0001);
    end
    ast_ready_i = '1;
    step_check_ready("bp.p2.ready", 1'b1);
    check("bp.p2.data", ast_data_o[0], 32'h5000_0002);
    drive(1, 0, 0, 0, 0, 32'h5000_0003);
    step_check_ready("bp.p3.ready", 1'b1);
    drive(1, 0, 1, 0, 0, 32'h5000_0004);
    step_check_ready("bp.p4.ready", 1'b1);
    check("bp.p4.eop", ast_endofpacket_o[0], 1'b1);
    drive(0, 0, 0, 0, 0, '0);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    check("bp.beats", mon0.size(), 4);
    for (int i = 0; i < 4; i++) begin
      logic [DW-1:0] exp_beat;
      exp_beat = 32'h5000_0001 + DW'(i);
      check($sformatf("bp.beat%0d", i), (i < mon0.size()) ? mon0[i] : '0, exp_beat);
    end

    // Reset on beat 2 of a 5-beat packet
    drive(1, 1, 0, 1, 0, 32'h8000_0001);
    step_check_ready("rst2.b1.ready", 1'b1);
    check("rst2.b1.valid", ast_valid_o, 3'b010);
    drive(1, 0, 0, 1, 0, 32'h8000_0002);
    srst = 1'b1;
    step_check_ready("rst2.b2.ready", 1'b0);
    check("rst2.valid", ast_valid_o, '0);
    check("rst2.cnt", pkt_cnt_o, '0);
    srst = 1'b0;
    for (int b = 3; b <= 5; b++) begin
      drive(1, 0, b == 5, 1, 0, 32'h8000_0000 + DW'(b));
      step_check_ready($sformatf("rst2.b%0d.ready", b), 1'b1);
      check($sformatf("rst2.b%0d.valid", b), ast_valid_o, '0);
    end
    drive(1, 1, 1, 2, 1, 32'h9000_0001);
    step_check_ready("rst2.next.ready", 1'b1);
    check("rst2.next.valid", ast_valid_o, 3'b100);
    check("rst2.next.data", ast_data_o[2], 32'h9000_0001);

    // 17 single-beat packets to dir 0: counter saturates at 15
    for (int p = 0; p < 17; p++) begin
      drive(1, 1, 1, 0, 0, 32'hC000_0000 + DW'(p));
      @(posedge clk);
      #1;
    end
    drive(0, 0, 0, 0, 0, '0);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    check("sat.cnt0", pkt_cnt_o[0], STAT_EN ? 4'd15 : 4'd0);
    check("sat.cnt1", pkt_cnt_o[1], 4'd0);
    check("sat.cnt2", pkt_cnt_o[2], STAT_EN ? 4'd1 : 4'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
